// File: rtl/rgb_mixer.sv
// rgb_mixer: three-channel RGB LED mixer.
// Each channel: 2-flop synchronizer -> (optional debouncer) -> quadrature decoder
// -> WIDTH-bit level counter -> PWM compare against a shared free-running counter.
// Optional feature macro: RGB_MIXER_DEBOUNCE_EN (adds a per-input debouncer of
// DEBOUNCE_LEN clocks; without it the decoder reads the synchronizer directly).
module rgb_mixer #(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_LEN = 8
) (
    input  logic clk,
    input  logic RSTB,
    input  logic enc0_a,
    input  logic enc0_b,
    input  logic enc1_a,
    input  logic enc1_b,
    input  logic enc2_a,
    input  logic enc2_b,
    output logic pwm0_out,
    output logic pwm1_out,
    output logic pwm2_out
);

    localparam int NCH = 3;
    localparam int NIN = 2 * NCH;

    // Raw pad inputs packed as {b,a} pairs per channel, channel 0 in the LSBs.
    logic [NIN-1:0] w_raw;
    assign w_raw = {enc2_b, enc2_a, enc1_b, enc1_a, enc0_b, enc0_a};

    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;

    // Two-stage synchronizer for every asynchronous encoder input.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    logic [NIN-1:0] w_dec_in;

`ifdef RGB_MIXER_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_LEN + 1);

    logic [NIN-1:0] r_deb;
    logic [DW-1:0]  r_deb_cnt [NIN];

    // Debouncer: accept a new value only after it has persisted DEBOUNCE_LEN clocks.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            r_deb <= '0;
            for (int i = 0; i < NIN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DW'(DEBOUNCE_LEN - 1)) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_dec_in = r_deb;
`else
    assign w_dec_in = r_sync2;
`endif

    // Per-channel A/B vectors (bit index = channel).
    logic [NCH-1:0] w_a;
    logic [NCH-1:0] w_b;
    logic [NCH-1:0] w_step;
    logic [NCH-1:0] w_up;

    logic [NCH-1:0] r_primed;
    logic [NCH-1:0] r_prev_a;
    logic [NCH-1:0] r_prev_b;
    logic [WIDTH-1:0] r_level [NCH];

    assign w_a = {w_dec_in[4], w_dec_in[2], w_dec_in[0]};
    assign w_b = {w_dec_in[5], w_dec_in[3], w_dec_in[1]};

    // A single-bit change is a step; a double change xors to zero and is ignored.
    // Direction: a differs from the previous b when A leads B (count up).
    assign w_step = r_primed & (w_a ^ r_prev_a ^ w_b ^ r_prev_b);
    assign w_up   = w_a ^ r_prev_b;

    // Quadrature decoder and wrapping level counters for all channels.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            r_primed <= '0;
            r_prev_a <= '0;
            r_prev_b <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_level[ch] <= '0;
            end
        end else begin
            r_primed <= {NCH{1'b1}};
            r_prev_a <= w_a;
            r_prev_b <= w_b;
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_step[ch]) begin
                    if (w_up[ch]) begin
                        r_level[ch] <= r_level[ch] + WIDTH'(1);
                    end else begin
                        r_level[ch] <= r_level[ch] - WIDTH'(1);
                    end
                end else begin
                    r_level[ch] <= r_level[ch];
                end
            end
        end
    end

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty [NCH];
    logic [WIDTH-1:0] w_duty_eff [NCH];
    logic [NCH-1:0]   r_pwm;

    // At the period start the freshly latched level is used so the whole period
    // sees one consistent duty value.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            w_duty_eff[ch] = r_duty[ch];
            if (r_cnt == '0) begin
                w_duty_eff[ch] = r_level[ch];
            end else begin
                w_duty_eff[ch] = r_duty[ch];
            end
        end
    end

    // Shared PWM counter, duty latch at period start, and registered compare outputs.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            r_cnt <= '0;
            r_pwm <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_duty[ch] <= '0;
            end
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            for (int ch = 0; ch < NCH; ch++) begin
                r_duty[ch] <= w_duty_eff[ch];
                r_pwm[ch]  <= (r_cnt < w_duty_eff[ch]);
            end
        end
    end

    assign pwm0_out = r_pwm[0];
    assign pwm1_out = r_pwm[1];
    assign pwm2_out = r_pwm[2];

endmodule

// File: tb/tb_rgb_mixer.sv
// Directed self-checking bench for rgb_mixer. Levels are observed through the
// PWM outputs by counting high clocks over 256-clock windows.
module tb_rgb_mixer;

    logic clk = 1'b0;
    logic RSTB;
    logic enc0_a, enc0_b, enc1_a, enc1_b, enc2_a, enc2_b;
    logic pwm0_out, pwm1_out, pwm2_out;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_cnt   [3];
    int rise_cnt [3];

    rgb_mixer #(.WIDTH(8), .DEBOUNCE_LEN(8)) dut (
        .clk      (clk),
        .RSTB     (RSTB),
        .enc0_a   (enc0_a),
        .enc0_b   (enc0_b),
        .enc1_a   (enc1_a),
        .enc1_b   (enc1_b),
        .enc2_a   (enc2_a),
        .enc2_b   (enc2_b),
        .pwm0_out (pwm0_out),
        .pwm1_out (pwm1_out),
        .pwm2_out (pwm2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_enc(input int ch, input logic a, input logic b);
        case (ch)
            0:       begin enc0_a = a; enc0_b = b; end
            1:       begin enc1_a = a; enc1_b = b; end
            2:       begin enc2_a = a; enc2_b = b; end
            default: begin end
        endcase
    endtask

    // Samples 256 consecutive clocks; counts high clocks and circular rising
    // edges per output. If poke_k >= 0, steps enc0 00->10 at that sample.
    task automatic measure(input int poke_k);
        logic [2:0] s, first_s, prev_s;
        first_s = 3'b000;
        prev_s  = 3'b000;
        for (int ch = 0; ch < 3; ch++) begin
            hi_cnt[ch]   = 0;
            rise_cnt[ch] = 0;
        end
        for (int k = 0; k < 256; k++) begin
            tick(1);
            s = {pwm2_out, pwm1_out, pwm0_out};
            if (k == 0) begin
                first_s = s;
            end else begin
                for (int ch = 0; ch < 3; ch++)
                    if (!prev_s[ch] && s[ch]) rise_cnt[ch]++;
            end
            for (int ch = 0; ch < 3; ch++)
                if (s[ch]) hi_cnt[ch]++;
            prev_s = s;
            if (k == poke_k) set_enc(0, 1'b1, 1'b0);
        end
        for (int ch = 0; ch < 3; ch++)
            if (!prev_s[ch] && first_s[ch]) rise_cnt[ch]++;
    endtask

    initial begin
        logic found;
        logic prev_p;
        RSTB = 1'b0;
        set_enc(0, 1'b0, 1'b0);
        set_enc(1, 1'b0, 1'b0);
        set_enc(2, 1'b0, 1'b0);

        // Reset held with random toggling inputs: outputs must stay low.
        for (int i = 0; i < 12; i++) begin
            enc0_a = 1'($urandom_range(0, 1)); enc0_b = 1'($urandom_range(0, 1));
            enc1_a = 1'($urandom_range(0, 1)); enc1_b = 1'($urandom_range(0, 1));
            enc2_a = 1'($urandom_range(0, 1)); enc2_b = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("rst_pwm0", int'(pwm0_out), 0);
        check("rst_pwm1", int'(pwm1_out), 0);
        check("rst_pwm2", int'(pwm2_out), 0);
        set_enc(0, 1'b0, 1'b0);
        set_enc(1, 1'b0, 1'b0);
        set_enc(2, 1'b0, 1'b0);
        tick(3);
        RSTB = 1'b1;
        tick(5);

        // enc0: 8 steps A leading B -> level 8.
        for (int r = 0; r < 2; r++) begin
            set_enc(0, 1'b1, 1'b0); tick(10);
            set_enc(0, 1'b1, 1'b1); tick(10);
            set_enc(0, 1'b0, 1'b1); tick(10);
            set_enc(0, 1'b0, 1'b0); tick(10);
        end
        // enc1: one step B leading from 0 -> wraps to 255.
        set_enc(1, 1'b0, 1'b1); tick(10);
        // enc2: one up step (level 1), then a double change 10->01 (ignored).
        set_enc(2, 1'b1, 1'b0); tick(10);
        set_enc(2, 1'b0, 1'b1); tick(10);

        tick(300);
        measure(-1);
        check("up8_hi0",    hi_cnt[0],   8);
        check("up8_rise0",  rise_cnt[0], 1);
        check("dn_hi1",     hi_cnt[1],   255);
        check("dn_rise1",   rise_cnt[1], 1);
        check("inv_hi2",    hi_cnt[2],   1);
        check("inv_rise2",  rise_cnt[2], 1);

        // Align to the period start (rising edge of pwm0 = counter 0).
        found  = 1'b0;
        prev_p = pwm0_out;
        for (int i = 0; i < 600 && !found; i++) begin
            tick(1);
            if (pwm0_out && !prev_p) found = 1'b1;
            prev_p = pwm0_out;
        end
        check("align_found", int'(found), 1);
        tick(255);
        // Level 8->9 mid-period: current period keeps 8, next period shows 9.
        measure(100);
        check("upd_old_hi0",   hi_cnt[0],   8);
        check("upd_old_rise0", rise_cnt[0], 1);
        measure(-1);
        check("upd_new_hi0",   hi_cnt[0],   9);
        check("upd_new_rise0", rise_cnt[0], 1);

        // enc1 up from 255 wraps to 0.
        set_enc(1, 1'b0, 1'b0);
        tick(300);
        measure(-1);
        check("wrap_hi1", hi_cnt[1], 0);

        // Simultaneous steps: enc0 up (10), enc1 down (255), enc2 up (2).
        set_enc(0, 1'b1, 1'b1);
        set_enc(1, 1'b0, 1'b1);
        set_enc(2, 1'b0, 1'b0);
        tick(300);
        measure(-1);
        check("sim_hi0", hi_cnt[0], 10);
        check("sim_hi1", hi_cnt[1], 255);
        check("sim_hi2", hi_cnt[2], 2);

`ifdef RGB_MIXER_DEBOUNCE_EN
        // Short A pulse (7 clocks) is rejected; an 8+ clock hold counts once.
        set_enc(0, 1'b0, 1'b1); tick(7);
        set_enc(0, 1'b1, 1'b1); tick(20);
        set_enc(0, 1'b0, 1'b1); tick(20);
        tick(300);
        measure(-1);
        check("deb_hi0", hi_cnt[0], 11);
`endif

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        tick(3);
        #2;
        RSTB = 1'b0;
        #1;
        check("arst_pwm0", int'(pwm0_out), 0);
        check("arst_pwm1", int'(pwm1_out), 0);
        check("arst_pwm2", int'(pwm2_out), 0);
        set_enc(0, 1'b0, 1'b0);
        set_enc(1, 1'b0, 1'b0);
        set_enc(2, 1'b0, 1'b0);
        tick(5);
        RSTB = 1'b1;
        tick(300);
        measure(-1);
        check("post_hi0", hi_cnt[0], 0);
        check("post_hi1", hi_cnt[1], 0);
        check("post_hi2", hi_cnt[2], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
